fetch_seq: RTL

Instruction-fetch sequencer for the single-issue MIPS core. It owns the fetch PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a 2-entry queue toward decode. It applies redirects from the branch/jump next-PC logic, squashing wrong-path words, and honours decode stalls without dropping instructions.

---
 rtl/fetch_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the fetch PC, issues single-outstanding
// imem requests and buffers returned words in a 2-entry queue toward decode.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcp4
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } q_entry_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            stale_q, stale_d;
    q_entry_t        q0_q, q0_d;
    q_entry_t        q1_q, q1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            if_valid_q, if_valid_d;
    logic            imem_req_q, imem_req_d;
    logic [XLEN-1:0] imem_addr_q, imem_addr_d;

    logic            gnt_acc;
    logic            push;
    logic            pop;
    q_entry_t        new_entry;

    // stale_q marks an ungranted request whose address predates a redirect
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        kill_d      = kill_q;
        stale_d     = stale_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        count_d     = count_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;
        pop         = if_valid_q && !stall;
        gnt_acc     = imem_req_q && imem_gnt;
        new_entry   = '{instr: imem_rdata, pc: req_pc_q};

        case (state_q)
            S_FETCH: begin
                if (gnt_acc) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    stale_d  = 1'b0;
                    if (stale_q) begin
                        kill_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    if (kill_q) begin
                        kill_d = 1'b0;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            default: state_d = S_FETCH;
        endcase

        // redirect overrides stall and any same-cycle push
        if (redirect) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            push    = 1'b0;
            pop     = 1'b0;
            count_d = '0;
            kill_d  = (state_q == S_WAIT) ? !imem_rvalid : gnt_acc;
            stale_d = (state_q == S_FETCH) && imem_req_q && !imem_gnt;
        end

        if (push && pop) begin
            if (count_q == 2'd1) begin
                q0_d = new_entry;
            end else begin
                q0_d = q1_q;
                q1_d = new_entry;
            end
        end else if (pop) begin
            q0_d    = q1_q;
            count_d = CNT_W'(count_q - 2'd1);
        end else if (push) begin
            if (count_q == 2'd0) begin
                q0_d = new_entry;
            end else begin
                q1_d = new_entry;
            end
            count_d = CNT_W'(count_q + 2'd1);
        end

        if_valid_d = (count_d != 2'd0);

        // a pending request keeps its address until granted
        if (state_d == S_FETCH) begin
            if (!(imem_req_q && !imem_gnt)) begin
                imem_req_d  = (count_d < 2'd2);
                imem_addr_d = pc_d;
            end
        end else begin
            imem_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            kill_q      <= 1'b0;
            stale_q     <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
            count_q     <= '0;
            if_valid_q  <= 1'b0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            stale_q     <= stale_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            count_q     <= count_d;
            if_valid_q  <= if_valid_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = q0_q.instr;
    assign if_pc     = q0_q.pc;
    assign if_pcp4   = if_pc + 32'd4;

endmodule
